seq_addsub64: RTL and testbench

SEQ_ADDSUB64 -- requirements
Module: seq_addsub64

---
 rtl/seq_addsub64_if.sv | 24 ++
 rtl/seq_addsub64.sv | 110 +++++++++++
 tb/tb_seq_addsub64.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_addsub64_if.sv
// Request/response bundle for the sequential 64-bit adder/subtractor.
// The master drives the operands and start; the slave returns status and results.
interface seq_addsub64_if;
  logic        start;
  logic        op;
  logic [63:0] a;
  logic [63:0] b;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        c_out;
  logic        overflow;

  modport master (
    output start, op, a, b, c_in,
    input  busy, done, result, c_out, overflow
  );

  modport slave (
    input  start, op, a, b, c_in,
    output busy, done, result, c_out, overflow
  );
endinterface

// File: rtl/seq_addsub64.sv
// 64-bit add/subtract computed serially as eight 8-bit ripple slices, one per clock.
// Subtract is performed as A + ~B + 1, so c_out is the inverted borrow.
module seq_addsub64 (
  input  logic           clk,
  input  logic           rst,
  seq_addsub64_if.slave  bus
);
  localparam int unsigned W  = 64;
  localparam int unsigned SW = 8;
  localparam int unsigned KW = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_n;
  logic [W-1:0]  opa, opa_n;
  logic [W-1:0]  opb, opb_n;
  logic [W-1:0]  acc, acc_n;
  logic          carry, carry_n;
  logic [KW-1:0] k, k_n;
  logic [W-1:0]  result_q, result_n;
  logic          c_out_q, c_out_n;
  logic          ovf_q, ovf_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;

  logic [SW-1:0] slice_a, slice_b;
  logic [SW:0]   slice_sum;
  logic [5:0]    slice_idx;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      k        <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      opa      <= opa_n;
      opb      <= opb_n;
      acc      <= acc_n;
      carry    <= carry_n;
      k        <= k_n;
      result_q <= result_n;
      c_out_q  <= c_out_n;
      ovf_q    <= ovf_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Next-state, slice arithmetic and output load
  always_comb begin
    state_n   = state;
    opa_n     = opa;
    opb_n     = opb;
    acc_n     = acc;
    carry_n   = carry;
    k_n       = k;
    result_n  = result_q;
    c_out_n   = c_out_q;
    ovf_n     = ovf_q;
    slice_idx = {k, 3'b000};
    slice_a   = opa[slice_idx +: SW];
    slice_b   = opb[slice_idx +: SW];
    slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{SW{1'b0}}, carry};

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = RUN;
          opa_n   = bus.a;
          opb_n   = bus.op ? ~bus.b : bus.b;
          carry_n = bus.op ? 1'b1 : bus.c_in;
          k_n     = '0;
        end
      end
      RUN: begin
        acc_n[slice_idx +: SW] = slice_sum[SW-1:0];
        carry_n = slice_sum[SW];
        k_n     = k + KW'(1);
        if (k == KW'(7)) begin
          state_n  = DONE;
          result_n = {slice_sum[SW-1:0], acc[W-SW-1:0]};
          c_out_n  = slice_sum[SW];
          // carry into bit 63 is recovered from the sum bit and its two operand bits
          ovf_n    = slice_sum[SW] ^ (slice_a[SW-1] ^ slice_b[SW-1] ^ slice_sum[SW-1]);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_seq_addsub64.sv
// Bench for seq_addsub64: directed vector table, random ops, and the
// ignored-start / mid-run reset sequences, checked through a result scoreboard.
module tb_seq_addsub64;
  logic clk = 1'b0;
  logic rst;

  seq_addsub64_if bus ();

  seq_addsub64 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] res;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural reference: plain 65-bit add or subtract
  function automatic exp_t model(input logic op, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin);
    exp_t        e;
    logic [64:0] s;
    if (!op) begin
      s    = {1'b0, a} + {1'b0, b} + 65'(cin);
      e.co = s[64];
      e.ov = (a[63] == b[63]) && (s[63] != a[63]);
    end else begin
      s    = {1'b0, a} - {1'b0, b};
      e.co = ~s[64];
      e.ov = (a[63] != b[63]) && (s[63] != a[63]);
    end
    e.res = s[63:0];
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending op
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 want no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", bus.result, e.res);
        chk("sb_c_out", 64'(bus.c_out), 64'(e.co));
        chk("sb_overflow", 64'(bus.overflow), 64'(e.ov));
      end
    end
  end

  // inj: cycle at which a stray start pulse is sampled; rst_at: cycle at which rst is sampled
  task automatic run_op(input logic op, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input bit tab, input logic [63:0] tres,
                        input logic tco, input logic tov, input int inj, input int rst_at);
    int          lat;
    logic [63:0] held;
    @(negedge clk);
    held      = bus.result;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.c_in  = cin;
    if (rst_at == 0) sb.push_back(model(op, a, b, cin));
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.a     = {$urandom, $urandom};
    bus.b     = {$urandom, $urandom};
    bus.c_in  = 1'($urandom);
    chk("busy_after_start", 64'(bus.busy), 64'(1));
    chk("done_after_start", 64'(bus.done), 64'(0));
    lat = 0;
    for (int n = 2; n <= 20; n++) begin
      if (n == inj) begin
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = '1;
        bus.b     = 64'h1;
      end
      if (n == rst_at) rst = 1'b1;
      @(negedge clk);
      if (n == inj) bus.start = 1'b0;
      if (n == rst_at) begin
        rst = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_result", bus.result, 64'h0);
        chk("rst_c_out", 64'(bus.c_out), 64'(0));
        return;
      end
      if (bus.done === 1'b1) begin
        lat = n - 1;
        break;
      end
      chk("result_hold", bus.result, held);
    end
    // lat counts edges from the start-sampling edge to the one raising done
    chk("latency", 64'(lat), 64'(8));
    if (lat == 0) sb.delete();
    if (tab) begin
      chk("tab_result", bus.result, tres);
      chk("tab_c_out", 64'(bus.c_out), 64'(tco));
      chk("tab_overflow", 64'(bus.overflow), 64'(tov));
    end
    @(negedge clk);
    chk("done_one_cycle", 64'(bus.done), 64'(0));
    chk("idle_after_done", 64'(bus.busy), 64'(0));
  endtask

  initial begin
    vec_t tab[11];
    tab[0]  = '{1'b0, 64'h1, 64'h1, 1'b1, 64'h3, 1'b0, 1'b0};
    tab[1]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    tab[2]  = '{1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tab[3]  = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tab[4]  = '{1'b1, 64'hF, 64'h10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tab[5]  = '{1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tab[6]  = '{1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tab[7]  = '{1'b1, 64'hF, 64'h10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tab[8]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    tab[9]  = '{1'b1, 64'h0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0};
    tab[10] = '{1'b1, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_done", 64'(bus.done), 64'(0));
    chk("reset_result", bus.result, 64'h0);
    chk("reset_c_out", 64'(bus.c_out), 64'(0));
    chk("reset_overflow", 64'(bus.overflow), 64'(0));
    rst = 1'b0;

    foreach (tab[i])
      run_op(tab[i].op, tab[i].a, tab[i].b, tab[i].cin, 1'b1,
             tab[i].res, tab[i].co, tab[i].ov, 0, 0);

    for (int i = 0; i < 8; i++)
      run_op(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
             1'b0, 64'h0, 1'b0, 1'b0, 0, 0);

    // stray start sampled at E3 must not disturb the running add
    run_op(1'b0, 64'h1234_5678, 64'h9ABC_DEF0, 1'b0, 1'b1, 64'hACF1_3568, 1'b0, 1'b0, 3, 0);
    repeat (3) @(negedge clk);

    // reset sampled at E4 aborts the op
    run_op(1'b0, 64'h5555, 64'h7777, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 0, 4);

    // reset wins over a simultaneous start
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("rst_over_start_busy", 64'(bus.busy), 64'(0));

    run_op(1'b0, 64'hFFFF, 64'hBA, 1'b1, 1'b1, 64'h1_00BA, 1'b0, 1'b0, 0, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
